// File: rtl/mem_pkg.sv
// Shared definitions for the sized memory: access size codes, FSM states and
// the alignment rule used by both the memory and the future cache fill path.
package mem_pkg;
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [1:0] {IDLE = 2'b00, BUSY = 2'b01, RESP = 2'b10} state_e;

  // The illegal size code 2'b11 is treated as misaligned so it is rejected the same way.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
    case (size)
      SZ_B:    return 1'b0;
      SZ_H:    return a[0];
      SZ_W:    return a != 2'b00;
      default: return 1'b1;
    endcase
  endfunction
endpackage

// File: rtl/sized_mem_ws_load_extend.sv
// Picks the addressed byte/half out of a word-aligned raw word and sign- or
// zero-extends it to 32 bits; word loads pass through unchanged.
module load_extend
  import mem_pkg::*;
(
  input  logic [31:0] raw_i,
  input  logic [1:0]  addr_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] rdata_o
);
  logic [31:0] sh;
  logic        sx;

  always_comb begin
    sh = raw_i >> {addr_i, 3'b000};
    sx = 1'b0;
    rdata_o = raw_i;
    case (funct3_i[1:0])
      SZ_B: begin
        sx = ~funct3_i[2] & sh[7];
        rdata_o = {{24{sx}}, sh[7:0]};
      end
      SZ_H: begin
        sx = ~funct3_i[2] & sh[15];
        rdata_o = {{16{sx}}, sh[15:0]};
      end
      default: rdata_o = raw_i;
    endcase
  end
endmodule

// File: rtl/sized_mem_ws.sv
// Byte-addressable unified I/D memory with req/ready handshake, a fixed number
// of wait states per access and rejection of misaligned or illegal-size accesses.
module sized_mem_ws
  import mem_pkg::*;
#(
  parameter int    DEPTH_BYTES = 256,
  parameter int    WAIT_CYCLES = 1,
  parameter string INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        busy,
  output logic        misalign_err
);
  localparam int AW = $clog2(DEPTH_BYTES);

  logic [7:0] mem_q [DEPTH_BYTES];

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [2:0]  f3_q, f3_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        ready_q, ready_d, err_q, err_d;

  logic          bad, mem_we;
  logic [3:0]    be;
  logic [31:0]   wsh, raw, ld;
  logic [AW-1:0] wa;
  logic          unused_addr;

  assign unused_addr = ^addr[31:AW];

  assign bad = is_misaligned(f3_q[1:0], addr_q[1:0]);
  assign wa  = addr_q & ~AW'(3);
  assign wsh = wdata_q << {addr_q[1:0], 3'b000};

  always_comb begin
    be = 4'b0000;
    case (f3_q[1:0])
      SZ_B:    be = 4'b0001 << addr_q[1:0];
      SZ_H:    be = 4'b0011 << addr_q[1:0];
      SZ_W:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  always_comb begin
    raw = '0;
    for (int i = 0; i < 4; i++) raw[8*i +: 8] = mem_q[wa | AW'(i)];
  end

  load_extend u_ext (
    .raw_i   (raw),
    .addr_i  (addr_q[1:0]),
    .funct3_i(f3_q),
    .rdata_o (ld)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    ready_d = 1'b0;
    err_d   = 1'b0;
    mem_we  = 1'b0;
    case (state_q)
      BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = RESP;
          ready_d = 1'b1;
          err_d   = bad;
          // The store commits only here, so a reset mid-flight leaves the array untouched.
          if (bad)       rdata_d = '0;
          else if (we_q) mem_we  = ~reset;
          else           rdata_d = ld;
        end
      end
      default: begin
        if (req) begin
          state_d = BUSY;
          cnt_d   = 4'(WAIT_CYCLES);
          we_d    = we;
          f3_d    = funct3;
          addr_d  = addr[AW-1:0];
          wdata_d = wdata;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem_q[wa | AW'(i)] <= wsh[8*i +: 8];
  end

  assign rdata        = rdata_q;
  assign ready        = ready_q;
  assign busy         = (state_q == BUSY);
  assign misalign_err = err_q;
endmodule

// File: tb/tb_sized_mem_ws.sv
// Self-checking bench: three memories (2, 3 and 0 wait states) driven with
// directed and random accesses and compared against a byte-array reference.
module tb_sized_mem_ws;
  logic        clk;
  logic        rst [3];
  logic        req [3];
  logic        we  [3];
  logic [2:0]  f3  [3];
  logic [31:0] ad  [3];
  logic [31:0] wd  [3];
  logic [31:0] rd  [3];
  logic        rdy [3];
  logic        bsy [3];
  logic        err [3];

  logic [7:0]  mm [3][256];
  logic [31:0] last_rd [3];
  logic [31:0] obs_rd;
  logic        obs_err;
  int          n_cmp = 0;
  int          n_err = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    sized_mem_ws #(
      .DEPTH_BYTES(256),
      .WAIT_CYCLES(g == 0 ? 2 : (g == 1 ? 3 : 0))
    ) u_dut (
      .clk(clk), .reset(rst[g]), .req(req[g]), .we(we[g]), .funct3(f3[g]),
      .addr(ad[g]), .wdata(wd[g]), .rdata(rd[g]), .ready(rdy[g]),
      .busy(bsy[g]), .misalign_err(err[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got=timeout exp=done");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int wc(input int d);
    return d == 0 ? 2 : (d == 1 ? 3 : 0);
  endfunction

  function automatic logic [31:0] ref_load(input int d, input logic [2:0] f, input logic [31:0] a);
    int n = 1 << f[1:0];
    logic [31:0] v = '0;
    for (int k = 0; k < n; k++) v[8*k +: 8] = mm[d][int'((a + 32'(k)) & 32'hFF)];
    if (!f[2] && n < 4 && v[8*n-1]) v = v - (32'd1 << (8*n));
    return v;
  endfunction

  task automatic acc(input int d, input bit w, input logic [2:0] f,
                     input logic [31:0] a, input logic [31:0] wdv);
    int lat;
    int n;
    logic [31:0] erd;
    bit eerr;
    n = 1 << f[1:0];
    eerr = (f[1:0] == 2'b11) || ((a % n) != 0);
    if (eerr) erd = '0;
    else if (w) begin
      erd = last_rd[d];
      for (int k = 0; k < n; k++) mm[d][int'((a + 32'(k)) & 32'hFF)] = wdv[8*k +: 8];
    end else erd = ref_load(d, f, a);
    last_rd[d] = erd;

    @(negedge clk);
    req[d] = 1'b1; we[d] = w; f3[d] = f; ad[d] = a; wd[d] = wdv;
    @(posedge clk); #1;
    req[d] = 1'b0; we[d] = 1'($urandom); f3[d] = 3'($urandom);
    ad[d] = $urandom; wd[d] = $urandom;
    chk("busy_after_accept", 32'(bsy[d]), 32'd1);
    lat = 0;
    while (!rdy[d] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, wc(d) + 1);
    chk("rdata", rd[d], erd);
    chk("misalign_err", 32'(err[d]), 32'(eerr));
    obs_rd  = rd[d];
    obs_err = err[d];
  endtask

  initial begin
    logic [31:0] a;
    logic [2:0]  f;
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1; req[i] = 1'b0; we[i] = 1'b0; f3[i] = '0;
      ad[i] = '0; wd[i] = '0; last_rd[i] = '0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      chk("reset_rdata", rd[i], 32'd0);
      chk("reset_ready", 32'(rdy[i]), 32'd0);
      chk("reset_busy", 32'(bsy[i]), 32'd0);
      chk("reset_err", 32'(err[i]), 32'd0);
    end

    // Fill memory 0 so every later load has known contents.
    for (int i = 0; i < 64; i++) acc(0, 1'b1, 3'b010, 32'(i * 4), $urandom);

    acc(0, 1'b1, 3'b010, 32'h80, 32'hDEADBEEF);
    acc(0, 1'b0, 3'b010, 32'h80, 32'h0);   chk("t1_lw", obs_rd, 32'hDEADBEEF);
    acc(0, 1'b0, 3'b000, 32'h83, 32'h0);   chk("t2_lb", obs_rd, 32'hFFFFFFDE);
    acc(0, 1'b0, 3'b100, 32'h83, 32'h0);   chk("t2_lbu", obs_rd, 32'h000000DE);
    acc(0, 1'b0, 3'b001, 32'h82, 32'h0);   chk("t2_lh", obs_rd, 32'hFFFFDEAD);
    acc(0, 1'b0, 3'b101, 32'h80, 32'h0);   chk("t2_lhu", obs_rd, 32'h0000BEEF);
    acc(0, 1'b1, 3'b001, 32'h81, 32'h1234); chk("t3_sh_err", 32'(obs_err), 32'd1);
    acc(0, 1'b0, 3'b010, 32'h80, 32'h0);   chk("t3_unchanged", obs_rd, 32'hDEADBEEF);
    acc(0, 1'b0, 3'b010, 32'h86, 32'h0);   chk("t3_lw_err_rdata", obs_rd, 32'h0);
    acc(0, 1'b0, 3'b011, 32'h80, 32'h0);   chk("t3_size11_err", 32'(obs_err), 32'd1);
    acc(0, 1'b1, 3'b000, 32'h1FF, 32'hAA);
    acc(0, 1'b0, 3'b100, 32'hFF, 32'h0);   chk("t4_wrap", obs_rd, 32'h000000AA);

    for (int i = 0; i < 200; i++) begin
      f = 3'($urandom_range(0, 7));
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & ~32'h3;
      acc(0, ($urandom_range(0, 2) == 0), f, a, $urandom);
    end

    // Reset one cycle into a 3-wait-state store must abort it.
    acc(1, 1'b1, 3'b010, 32'h90, 32'h11223344);
    @(negedge clk);
    req[1] = 1'b1; we[1] = 1'b1; f3[1] = 3'b010; ad[1] = 32'h90; wd[1] = 32'hCAFEF00D;
    @(posedge clk); #1;
    req[1] = 1'b0;
    @(posedge clk); #1;
    chk("t5_busy_before", 32'(bsy[1]), 32'd1);
    rst[1] = 1'b1;
    #1;
    chk("t5_rdata", rd[1], 32'd0);
    chk("t5_ready", 32'(rdy[1]), 32'd0);
    chk("t5_busy", 32'(bsy[1]), 32'd0);
    chk("t5_err", 32'(err[1]), 32'd0);
    @(negedge clk);
    rst[1] = 1'b0;
    last_rd[1] = '0;
    repeat (5) @(posedge clk);
    #1 chk("t5_idle", 32'(bsy[1]), 32'd0);
    acc(1, 1'b0, 3'b010, 32'h90, 32'h0);   chk("t5_word_kept", obs_rd, 32'h11223344);

    // Zero wait states with req held: one completion every second cycle.
    for (int k = 0; k < 4; k++) acc(2, 1'b1, 3'b010, 32'h10 + 32'(4 * k), $urandom);
    @(negedge clk);
    req[2] = 1'b1; we[2] = 1'b0; f3[2] = 3'b010; ad[2] = 32'h10;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      chk("t6_ready", 32'(rdy[2]), 32'(c % 2));
      chk("t6_busy", 32'(bsy[2]), 32'((c + 1) % 2));
      if (c % 2 == 1) begin
        chk("t6_rdata", rd[2], ref_load(2, 3'b010, 32'h10 + 32'(4 * (c / 2))));
        ad[2] = 32'h10 + 32'(4 * (c / 2 + 1));
        if (c == 7) req[2] = 1'b0;
      end
    end
    @(posedge clk); #1;
    chk("t6_idle_ready", 32'(rdy[2]), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
